// File: rtl/tri_bus_arb_pkg.sv
// ----------------------------------------------------------------------------
// tri_bus_arb_pkg : shared types, defaults and helpers for the bus arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package tri_bus_arb_pkg;

  localparam int DEF_NREQ       = 4;
  localparam int DEF_MAX_TENURE = 8;
  localparam int DEF_TURNAROUND = 1;
  localparam int MAX_NREQ       = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } state_e;

  // Callers slice the low NREQ bits of the result.
  function automatic logic [MAX_NREQ-1:0] onehot_of(input logic [31:0] idx);
    logic [MAX_NREQ-1:0] v;
    v = '0;
    v[idx[3:0]] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick : combinational round-robin picker (first set bit at or after ptr)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic            valid,
  output logic [ID_W-1:0] idx
);

  int cand;

  // Walk the request vector from ptr with wrap; first hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!valid && req[cand[ID_W-1:0]]) begin
        valid = 1'b1;
        idx   = cand[ID_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tri_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tri_bus_arbiter : owner arbitration for a shared resolved net, with tenure
//                   limit and all-drivers-off turnaround between owners
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tri_bus_arbiter
  import tri_bus_arb_pkg::*;
#(
  parameter int NREQ       = DEF_NREQ,
  parameter int MAX_TENURE = DEF_MAX_TENURE,
  parameter int TURNAROUND = DEF_TURNAROUND,
  parameter int ID_W       = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] last,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] drive_en,
  output logic [ID_W-1:0] owner_id,
  output logic            bus_busy,
  output logic            tenure_expired,
  output logic            abort
);

  localparam int TEN_W  = (MAX_TENURE > 1) ? $clog2(MAX_TENURE) : 1;
  localparam int TURN_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic              busy_q, busy_d;
  logic              texp_q, texp_d;
  logic              abort_q, abort_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TEN_W-1:0]  tenure_q, tenure_d;
  logic [TURN_W-1:0] turn_q, turn_d;

  logic              pick_valid;
  logic [ID_W-1:0]   pick_idx;
  logic [MAX_NREQ-1:0] pick_oh;
  logic              start_own;
  logic              release_own;
  logic              tenure_max;
  logic              others_req;

  rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign pick_oh    = onehot_of(32'(pick_idx));
  assign tenure_max = (tenure_q == TEN_W'(MAX_TENURE - 1));
  assign others_req = |(req & ~grant_q);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    texp_d      = 1'b0;
    abort_d     = 1'b0;
    rr_ptr_d    = rr_ptr_q;
    tenure_d    = tenure_q;
    turn_d      = turn_q;
    start_own   = 1'b0;
    release_own = 1'b0;

    case (state_q)
      ST_IDLE: start_own = pick_valid;
      ST_OWN: begin
        // last outranks a dropped req, which outranks tenure expiry.
        if (last[owner_q]) begin
          release_own = 1'b1;
        end else if (!req[owner_q]) begin
          release_own = 1'b1;
          abort_d     = 1'b1;
        end else if (tenure_max && others_req) begin
          release_own = 1'b1;
          texp_d      = 1'b1;
        end else if (!tenure_max) begin
          tenure_d = tenure_q + 1'b1;
        end
      end
      ST_TURN: begin
        if (turn_q == '0) begin
          if (pick_valid) begin
            start_own = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          turn_d = turn_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (release_own) begin
      state_d = ST_TURN;
      grant_d = '0;
      turn_d  = TURN_W'(TURNAROUND - 1);
    end

    if (start_own) begin
      state_d  = ST_OWN;
      grant_d  = pick_oh[NREQ-1:0];
      owner_d  = pick_idx;
      busy_d   = 1'b1;
      tenure_d = '0;
      rr_ptr_d = (pick_idx == ID_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      busy_q   <= 1'b0;
      texp_q   <= 1'b0;
      abort_q  <= 1'b0;
      rr_ptr_q <= '0;
      tenure_q <= '0;
      turn_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      busy_q   <= busy_d;
      texp_q   <= texp_d;
      abort_q  <= abort_d;
      rr_ptr_q <= rr_ptr_d;
      tenure_q <= tenure_d;
      turn_q   <= turn_d;
    end
  end

  // grant is already zero outside OWN, so it doubles as the driver enable.
  assign grant          = grant_q;
  assign drive_en       = grant_q;
  assign owner_id       = owner_q;
  assign bus_busy       = busy_q;
  assign tenure_expired = texp_q;
  assign abort          = abort_q;

endmodule

`default_nettype wire

// File: tb/tb_tri_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tri_bus_arbiter : directed vector bench for tri_bus_arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_tri_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0, last = '0;
  logic [3:0] req3 = '0, last3 = '0;

  logic [3:0] grant, drive_en, grant3, drive_en3;
  logic [1:0] owner_id, owner_id3;
  logic       bus_busy, tenure_expired, abort;
  logic       bus_busy3, tenure_expired3, abort3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tri_bus_arbiter #(.NREQ(4), .MAX_TENURE(8), .TURNAROUND(1)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last),
    .grant(grant), .drive_en(drive_en), .owner_id(owner_id),
    .bus_busy(bus_busy), .tenure_expired(tenure_expired), .abort(abort)
  );

  tri_bus_arbiter #(.NREQ(4), .MAX_TENURE(8), .TURNAROUND(3)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .last(last3),
    .grant(grant3), .drive_en(drive_en3), .owner_id(owner_id3),
    .bus_busy(bus_busy3), .tenure_expired(tenure_expired3), .abort(abort3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bus-safety invariants on both instances, sampled mid-cycle.
  logic [3:0] prev_de = '0, prev_de3 = '0;
  always @(negedge clk) begin
    chk("onehot0_de", 32'($onehot0(drive_en)), 32'd1);
    chk("onehot0_de3", 32'($onehot0(drive_en3)), 32'd1);
    chk("gap_de", 32'(prev_de != 0 && drive_en != 0 && drive_en != prev_de), 32'd0);
    chk("gap_de3", 32'(prev_de3 != 0 && drive_en3 != 0 && drive_en3 != prev_de3), 32'd0);
    prev_de  = drive_en;
    prev_de3 = drive_en3;
  end

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] last;
    logic [3:0] g;
    logic [1:0] own;
    logic       busy;
    logic       texp;
    logic       abrt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] r, input logic [3:0] l, input logic [3:0] g,
                     input logic [1:0] o, input logic b, input logic t, input logic a);
    vec_t v;
    v.req = r; v.last = l; v.g = g; v.own = o; v.busy = b; v.texp = t; v.abrt = a;
    vecs.push_back(v);
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] o,
                         input logic b, input logic t, input logic a);
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_drive_en"}, 32'(drive_en), 32'(g));
    chk({tag, "_owner"}, 32'(owner_id), 32'(o));
    chk({tag, "_busy"}, 32'(bus_busy), 32'(b));
    chk({tag, "_texp"}, 32'(tenure_expired), 32'(t));
    chk({tag, "_abort"}, 32'(abort), 32'(a));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_g;
    int n;

    // req, last -> grant, owner, busy, texp, abort
    add(4'b0010, 4'b0000, 4'b0010, 2'd1, 1, 0, 0);
    add(4'b0010, 4'b0000, 4'b0010, 2'd1, 1, 0, 0);
    add(4'b0010, 4'b0000, 4'b0010, 2'd1, 1, 0, 0);
    add(4'b0010, 4'b0010, 4'b0000, 2'd1, 1, 0, 0);
    add(4'b0000, 4'b0000, 4'b0000, 2'd1, 0, 0, 0);
    add(4'b0000, 4'b0000, 4'b0000, 2'd1, 0, 0, 0);
    add(4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 0, 0);
    add(4'b0101, 4'b0000, 4'b0100, 2'd2, 1, 0, 0);
    add(4'b0001, 4'b0000, 4'b0000, 2'd2, 1, 0, 1);
    add(4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0, 0);
    add(4'b0001, 4'b0001, 4'b0000, 2'd0, 1, 0, 0);
    add(4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);
    add(4'b1000, 4'b0000, 4'b1000, 2'd3, 1, 0, 0);
    add(4'b0000, 4'b1000, 4'b0000, 2'd3, 1, 0, 0);
    add(4'b0000, 4'b0000, 4'b0000, 2'd3, 0, 0, 0);
    add(4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0, 0);
    add(4'b0011, 4'b0010, 4'b0001, 2'd0, 1, 0, 0);
    add(4'b0011, 4'b0001, 4'b0000, 2'd0, 1, 0, 0);
    add(4'b0011, 4'b0000, 4'b0010, 2'd1, 1, 0, 0);
    add(4'b0000, 4'b0010, 4'b0000, 2'd1, 1, 0, 0);
    add(4'b0000, 4'b0000, 4'b0000, 2'd1, 0, 0, 0);

    rst = 1'b1;
    step();
    step();
    chk_all("reset", 4'b0000, 2'd0, 0, 0, 0);
    chk("reset_de3", 32'(drive_en3), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      req  = vecs[i].req;
      last = vecs[i].last;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].g, vecs[i].own, vecs[i].busy,
              vecs[i].texp, vecs[i].abrt);
    end

    // Full contention: 8-cycle tenures, 1-cycle gaps, order 0,1,2,3,0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1111;
    last = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'(1 << (k % 4));
      for (int c = 0; c < 8; c++) begin
        step();
        chk_all($sformatf("rot%0d_c%0d", k, c), exp_g, 2'(k % 4), 1, 0, 0);
      end
      if (k < 4) begin
        step();
        chk_all($sformatf("rot%0d_gap", k), 4'b0000, 2'(k % 4), 1, 1, 0);
      end
    end
    req = 4'b0000;
    step();
    chk_all("rot_drop", 4'b0000, 2'd0, 1, 0, 1);
    step();
    chk_all("rot_idle", 4'b0000, 2'd0, 0, 0, 0);

    // Lone requester keeps the bus with no expiry.
    req = 4'b1000;
    for (int c = 0; c < 40; c++) begin
      step();
      chk("lone_grant", 32'(drive_en), 32'(4'b1000));
      chk("lone_texp", 32'(tenure_expired), 32'd0);
    end
    req = 4'b1010;
    n = 0;
    do begin
      step();
      n++;
    end while (drive_en != 0 && n < 8);
    chk("lone_released", 32'(drive_en), 32'd0);
    chk("lone_texp_pulse", 32'(tenure_expired), 32'd1);
    step();
    chk_all("lone_next", 4'b0010, 2'd1, 1, 0, 0);
    req = 4'b0000;
    step();
    step();
    chk("lone_idle", 32'(bus_busy), 32'd0);

    // Reset mid-ownership.
    req = 4'b0010;
    step();
    chk_all("pre_rst", 4'b0010, 2'd1, 1, 0, 0);
    rst = 1'b1;
    step();
    chk_all("mid_rst", 4'b0000, 2'd0, 0, 0, 0);
    rst = 1'b0;
    req = 4'b0011;
    step();
    chk_all("post_rst", 4'b0001, 2'd0, 1, 0, 0);
    rst = 1'b1;
    step();
    chk_all("mid_rst2", 4'b0000, 2'd0, 0, 0, 0);
    rst = 1'b0;
    step();
    chk_all("post_rst2", 4'b0001, 2'd0, 1, 0, 0);
    req = 4'b0000;
    last = 4'b0001;
    step();
    last = 4'b0000;
    step();

    // Three-cycle turnaround instance.
    req3 = 4'b0001;
    step();
    chk("t3_own0", 32'(drive_en3), 32'(4'b0001));
    req3 = 4'b0011;
    last3 = 4'b0001;
    step();
    last3 = 4'b0000;
    chk("t3_gap1", 32'(drive_en3), 32'd0);
    chk("t3_busy", 32'(bus_busy3), 32'd1);
    step();
    chk("t3_gap2", 32'(drive_en3), 32'd0);
    step();
    chk("t3_gap3", 32'(drive_en3), 32'd0);
    step();
    chk("t3_own1", 32'(drive_en3), 32'(4'b0010));
    chk("t3_owner", 32'(owner_id3), 32'd1);
    req3 = 4'b0000;
    step();
    chk("t3_abort", 32'(abort3), 32'd1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tri_bus_arbiter.md
Name: tri_bus_arbiter

Overview:
- Arbitrates ownership of one shared multi-driven resolved net (tri/wor/wand style bus) among NREQ requesters.
- Produces one-hot grant and per-requester driver enables, so at most one agent drives the net in any cycle.
- Enforces a tenure limit and a mandatory all-drivers-off turnaround gap between owners.
- Sits beside the shared net. Each requester gates its continuous assign with its drive_en bit.

Parameters:
- NREQ, 4, number of requesters (2..16).
- MAX_TENURE, 8, maximum cycles an owner holds the bus while another request is pending (>=1).
- TURNAROUND, 1, idle cycles with all drive_en low between owners (>=1).
- ID_W, $clog2(NREQ), width of owner_id.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  NREQ  per-requester bus request, level, held until done.
- last  input  NREQ  per-requester "final drive cycle" strobe; honoured only from the current owner.
- grant  output  NREQ  one-hot current owner; all zero when no owner.
- drive_en  output  NREQ  per-requester output enable; equals grant in OWN, zero otherwise.
- owner_id  output  ID_W  index of current/last owner.
- bus_busy  output  1  high in OWN and TURN.
- tenure_expired  output  1  one-cycle pulse when an owner is forcibly released.
- abort  output  1  one-cycle pulse when the owner drops req without last.

Behaviour:
- All outputs are registered.
- Reset: state IDLE, grant 0, drive_en 0, owner_id 0, bus_busy 0, tenure_expired 0, abort 0, rr_ptr 0, tenure count 0.
- rst mid-ownership clears drive_en on the next edge. No turnaround is inserted after reset.
- States are IDLE, OWN and TURN.
- IDLE:
  - If any req bit is set at edge t, pick the winner by round robin starting at rr_ptr.
  - At t+1: grant/drive_en = onehot(winner), owner_id = winner, bus_busy = 1, state OWN, tenure = 0, rr_ptr = (winner+1) mod NREQ.
  - Latency from req to drive_en is 1 cycle.
- OWN: tenure increments each cycle and saturates at MAX_TENURE-1. The owner is released on the first of these conditions, checked in priority order:
  - (a) last[owner]=1: normal release.
  - (b) req[owner]=0: abort pulses next cycle.
  - (c) tenure==MAX_TENURE-1 and any other req bit is set: tenure_expired pulses next cycle.
- Release: in the next cycle grant/drive_en = 0, state TURN, turnaround counter = TURNAROUND-1. owner_id holds its value.
- Tenure with no competitor: the owner keeps the bus indefinitely and no pulse is produced.
- Pulses are coincident: last with req low counts as a normal release, with no abort. last and tenure expiry together give a normal release, with no tenure_expired.
- TURN:
  - drive_en stays 0 for exactly TURNAROUND cycles.
  - On the final TURN cycle, arbitration runs as in IDLE.
  - If a winner exists, OWN begins on the next cycle, so the gap is exactly TURNAROUND cycles. Otherwise the state becomes IDLE and bus_busy = 0.
- Round robin:
  - The last owner has the lowest priority at the next arbitration.
  - Wrap-around goes from NREQ-1 to 0.
  - A requester that releases and re-requests immediately is served only if no other req bit is set.
- Invariants:
  - $onehot0(drive_en) in every cycle.
  - drive_en is never nonzero in the cycle immediately after a different owner's drive_en.
- last bits from non-owners are ignored.

Decomposition:
- Package tri_bus_arb_pkg holds:
  - state enum {ST_IDLE, ST_OWN, ST_TURN};
  - a function that returns a NREQ-bit one-hot from an index;
  - localparams for default NREQ/MAX_TENURE/TURNAROUND.
- Sub-module rr_pick (combinational). Inputs req[NREQ], ptr[ID_W]; outputs valid and idx[ID_W]. It is a rotate-then-priority-encode picker, reused by other arbiters in the design.
- tri_bus_arbiter holds the FSM, tenure and turnaround counters, and rr_ptr.

Test Plan:
- Reset, then req=4'b0010 at cycle 5 -> grant=4'b0010, drive_en=4'b0010, owner_id=1 at cycle 6. Then last[1]=1 at cycle 9 -> drive_en=0 at cycle 10, bus_busy=0 at cycle 11 (TURNAROUND=1).
- Setup: req=4'b1111 held, last never asserted, MAX_TENURE=8.
  - Required owner order is 0,1,2,3,0.
  - Each owner drives 8 cycles with a 1-cycle gap, and tenure_expired pulses once per handover.
- Setup: owner 2, and req[2] drops at cycle 20 with no last -> abort=1 and drive_en=0 at cycle 21. With req[0] pending, grant=4'b0001 at cycle 22.
- Setup: lone requester 3 held for 40 cycles -> drive_en=4'b1000 continuously, tenure_expired never pulses. Then req[1] rises at cycle 50 -> owner 3 released within MAX_TENURE cycles.
- Setup: TURNAROUND=3, and owner 0 asserts last while req[1] is set -> exactly 3 cycles with drive_en=0, then drive_en=4'b0010.
- Setup: rst asserted while owner 1 is in OWN -> next cycle all outputs are 0 and state IDLE. With req=4'b0011 afterwards, the grant goes to 0 (rr_ptr reset).
- Throughout all tests, assert $onehot0(drive_en) and the one-cycle-gap invariant.
